// File: rtl/baccarat_pkg.sv
// Shared constants and types for the baccarat bankroll ledger.
// Wager kinds, ledger FSM states and the stored-wager slot layout.
package baccarat_pkg;

    localparam logic [1:0] BET_NONE   = 2'b00;
    localparam logic [1:0] BET_PLAYER = 2'b01;
    localparam logic [1:0] BET_BANKER = 2'b10;
    localparam logic [1:0] BET_TIE    = 2'b11;

    // Slot amounts are held at a fixed maximum width; unused upper bits stay zero.
    localparam int SLOT_AMT_W = 32;

    typedef enum logic [1:0] {
        ST_BETTING = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_DONE    = 2'd2
    } ledger_state_e;

    typedef struct packed {
        logic [1:0]            kind;
        logic [SLOT_AMT_W-1:0] amount;
    } slot_t;

endpackage

// File: rtl/baccarat_ledger_if.sv
// Bet-entry, round-result and balance-display signals of the ledger.
// master = front end / game side, slave = the ledger itself.
interface baccarat_ledger_if #(
    parameter int BAL_W = 8,
    parameter int BET_W = 8,
    parameter int NBETS = 4
);
    localparam int CNT_W = $clog2(NBETS + 1);

    logic             bet_valid;
    logic [1:0]       bet_type;
    logic [BET_W-1:0] bet_amount;
    logic             bet_ready;
    logic             round_done;
    logic             player_win;
    logic             dealer_win;
    logic [BAL_W-1:0] balance;
    logic             bet_reject;
    logic             money_err;
    logic             settle_busy;
    logic             settle_done;
    logic [CNT_W-1:0] bet_count;

    modport master (
        output bet_valid, bet_type, bet_amount, round_done, player_win, dealer_win,
        input  bet_ready, balance, bet_reject, money_err, settle_busy, settle_done, bet_count
    );

    modport slave (
        input  bet_valid, bet_type, bet_amount, round_done, player_win, dealer_win,
        output bet_ready, balance, bet_reject, money_err, settle_busy, settle_done, bet_count
    );

endinterface

// File: rtl/baccarat_payout.sv
// Combinational credit for one stored wager given the latched round result.
// Winning stake is returned together with the winnings.
module baccarat_payout
    import baccarat_pkg::*;
#(
    parameter int BET_W    = 8,
    parameter int TIE_MULT = 8
) (
    input  logic [1:0]       kind,
    input  logic [BET_W-1:0] amount,
    input  logic             player_win,
    input  logic             dealer_win,
    output logic [BET_W+4:0] credit
);
    localparam int CR_W = BET_W + 5;
    localparam logic [CR_W-1:0] TIE_K = CR_W'(TIE_MULT + 1);

    logic [CR_W-1:0] amt_ext;
    assign amt_ext = CR_W'(amount);

    always_comb begin
        credit = '0;
        if (player_win && dealer_win) begin
            if (kind == BET_TIE) credit = amt_ext * TIE_K;
        end else if (player_win) begin
            if (kind == BET_PLAYER) credit = amt_ext << 1;
        end else if (dealer_win) begin
            if (kind == BET_BANKER) credit = amt_ext << 1;
        end
    end

endmodule

// File: rtl/baccarat_ledger.sv
// Bankroll ledger: takes up to NBETS wagers per round, deducting each stake,
// then settles the stored slots one per cycle with saturating credit.
module baccarat_ledger
    import baccarat_pkg::*;
#(
    parameter int BAL_W    = 8,
    parameter int BET_W    = 8,
    parameter int NBETS    = 4,
    parameter int TIE_MULT = 8,
    parameter int INIT_BAL = 100
) (
    input logic               clk,
    input logic               reset,
    baccarat_ledger_if.slave  bus
);
    localparam int CNT_W = $clog2(NBETS + 1);
    localparam int IDX_W = (NBETS > 1) ? $clog2(NBETS) : 1;
    localparam int SUM_W = BAL_W + BET_W + 5;
    localparam logic [SUM_W-1:0] BAL_MAX = {{(SUM_W-BAL_W){1'b0}}, {BAL_W{1'b1}}};

    ledger_state_e    state_reg, state_next;
    logic [BAL_W-1:0] balance_reg, balance_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             pw_reg, pw_next;
    logic             dw_reg, dw_next;
    logic             reject_reg, reject_next;
    logic             err_reg, err_next;
    logic             ready;
    logic             slot_we, slot_clr;

    slot_t            slot_reg [NBETS];
    slot_t            wr_slot;
    slot_t            cur_slot;
    logic [IDX_W-1:0] wr_idx;
    logic [NBETS-1:0] slot_hit;
    logic [BET_W+4:0] credit;
    logic [SUM_W-1:0] bal_ext, amt_ext, sum;
    logic             reject_cond, settle_last;

    assign bal_ext     = SUM_W'(balance_reg);
    assign amt_ext     = SUM_W'(bus.bet_amount);
    assign sum         = bal_ext + SUM_W'(credit);
    assign reject_cond = (bus.bet_type == BET_NONE) || (bus.bet_amount == '0) || (amt_ext > bal_ext);
    assign settle_last = (CNT_W'(idx_reg) + CNT_W'(1)) == count_reg;

    assign wr_idx         = count_reg[IDX_W-1:0];
    assign wr_slot.kind   = bus.bet_type;
    assign wr_slot.amount = SLOT_AMT_W'(bus.bet_amount);
    assign cur_slot       = slot_reg[idx_reg];

    genvar gi;
    generate
        for (gi = 0; gi < NBETS; gi++) begin : g_slot_hit
            assign slot_hit[gi] = slot_we && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    baccarat_payout #(
        .BET_W    (BET_W),
        .TIE_MULT (TIE_MULT)
    ) u_payout (
        .kind       (cur_slot.kind),
        .amount     (cur_slot.amount[BET_W-1:0]),
        .player_win (pw_reg),
        .dealer_win (dw_reg),
        .credit     (credit)
    );

    always_comb begin
        state_next   = state_reg;
        balance_next = balance_reg;
        count_next   = count_reg;
        idx_next     = idx_reg;
        pw_next      = pw_reg;
        dw_next      = dw_reg;
        reject_next  = 1'b0;
        err_next     = err_reg;
        slot_we      = 1'b0;
        slot_clr     = 1'b0;
        ready        = (state_reg == ST_BETTING) && (count_reg < CNT_W'(NBETS)) && !bus.round_done;

        case (state_reg)
            ST_BETTING: begin
                // A round result wins over a wager offered in the same cycle.
                if (bus.round_done) begin
                    pw_next    = bus.player_win;
                    dw_next    = bus.dealer_win;
                    idx_next   = '0;
                    state_next = (count_reg == '0) ? ST_DONE : ST_SETTLE;
                end else if (bus.bet_valid && ready) begin
                    if (reject_cond) begin
                        reject_next = 1'b1;
                    end else begin
                        balance_next = BAL_W'(bal_ext - amt_ext);
                        count_next   = count_reg + CNT_W'(1);
                        err_next     = 1'b0;
                        slot_we      = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (sum > BAL_MAX) begin
                    balance_next = '1;
                    err_next     = 1'b1;
                end else begin
                    balance_next = BAL_W'(sum);
                end
                idx_next = idx_reg + IDX_W'(1);
                if (settle_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                count_next = '0;
                slot_clr   = 1'b1;
                state_next = ST_BETTING;
            end
            default: state_next = ST_BETTING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_BETTING;
            balance_reg <= BAL_W'(INIT_BAL);
            count_reg   <= '0;
            idx_reg     <= '0;
            pw_reg      <= 1'b0;
            dw_reg      <= 1'b0;
            reject_reg  <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            balance_reg <= balance_next;
            count_reg   <= count_next;
            idx_reg     <= idx_next;
            pw_reg      <= pw_next;
            dw_reg      <= dw_next;
            reject_reg  <= reject_next;
            err_reg     <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBETS; i++) begin
            if (reset || slot_clr) slot_reg[i] <= '0;
            else if (slot_hit[i])  slot_reg[i] <= wr_slot;
        end
    end

    assign bus.bet_ready   = ready;
    assign bus.balance     = balance_reg;
    assign bus.bet_reject  = reject_reg;
    assign bus.money_err   = err_reg;
    assign bus.settle_busy = (state_reg == ST_SETTLE);
    assign bus.settle_done = (state_reg == ST_DONE);
    assign bus.bet_count   = count_reg;

endmodule

// File: tb/tb_baccarat_ledger.sv
// Self-checking bench for baccarat_ledger against a queue-based bankroll model.
module tb_baccarat_ledger;
    import baccarat_pkg::*;

    localparam int BAL_W    = 8;
    localparam int BET_W    = 8;
    localparam int NBETS    = 4;
    localparam int TIE_MULT = 8;
    localparam int INIT_BAL = 100;
    localparam int CNT_W    = $clog2(NBETS + 1);
    localparam int MAXBAL   = (1 << BAL_W) - 1;

    logic clk = 1'b0;
    logic reset;

    baccarat_ledger_if #(.BAL_W(BAL_W), .BET_W(BET_W), .NBETS(NBETS)) bus ();

    baccarat_ledger #(
        .BAL_W(BAL_W), .BET_W(BET_W), .NBETS(NBETS), .TIE_MULT(TIE_MULT), .INIT_BAL(INIT_BAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bankroll, sticky error flag and the wagers held this round.
    int m_bal;
    bit m_err;
    int q_kind[$];
    int q_amt[$];

    task automatic model_reset();
        m_bal = INIT_BAL;
        m_err = 1'b0;
        q_kind.delete();
        q_amt.delete();
    endtask

    function automatic int credit_of(int kind, int amt, bit pw, bit dw);
        if (pw && dw) return (kind == 3) ? amt * (TIE_MULT + 1) : 0;
        if (pw)       return (kind == 1) ? amt * 2 : 0;
        if (dw)       return (kind == 2) ? amt * 2 : 0;
        return 0;
    endfunction

    task automatic do_reset();
        bus.bet_valid  = 1'b0;
        bus.bet_type   = 2'b00;
        bus.bet_amount = '0;
        bus.round_done = 1'b0;
        bus.player_win = 1'b0;
        bus.dealer_win = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic place_bet(input logic [1:0] kind, input int amt);
        bit exp_ready, exp_rej;
        exp_ready = (q_kind.size() < NBETS);
        exp_rej   = 1'b0;
        bus.bet_valid  = 1'b1;
        bus.bet_type   = kind;
        bus.bet_amount = BET_W'(amt);
        #1;
        n_checks++;
        if (bus.bet_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL bet_ready: got %0b expected %0b", bus.bet_ready, exp_ready);
        end
        @(posedge clk);
        #1;
        bus.bet_valid = 1'b0;
        if (exp_ready) begin
            if (kind == BET_NONE || amt == 0 || amt > m_bal) begin
                exp_rej = 1'b1;
            end else begin
                m_bal -= amt;
                m_err  = 1'b0;
                q_kind.push_back(int'(kind));
                q_amt.push_back(amt);
            end
        end
        $display("bet type=%0d amt=%0d ready=%0b reject=%0b balance=%0d count=%0d",
                 kind, amt, exp_ready, bus.bet_reject, bus.balance, bus.bet_count);
        n_checks++;
        if (bus.bet_reject !== exp_rej) begin
            n_fail++;
            $display("FAIL bet_reject: got %0b expected %0b", bus.bet_reject, exp_rej);
        end
        n_checks++;
        if (bus.balance !== BAL_W'(m_bal)) begin
            n_fail++;
            $display("FAIL bet_balance: got %0d expected %0d", bus.balance, m_bal);
        end
        n_checks++;
        if (bus.bet_count !== CNT_W'(q_kind.size())) begin
            n_fail++;
            $display("FAIL bet_count: got %0d expected %0d", bus.bet_count, q_kind.size());
        end
        n_checks++;
        if (bus.money_err !== m_err) begin
            n_fail++;
            $display("FAIL bet_money_err: got %0b expected %0b", bus.money_err, m_err);
        end
    endtask

    // collide: offer an acceptable wager alongside round_done and keep it up through settlement.
    task automatic run_round(input bit pw, input bit dw, input bit collide);
        int n, total, cycles, busy;
        bit exp_err;
        n = q_kind.size();
        total = m_bal;
        foreach (q_kind[i]) total += credit_of(q_kind[i], q_amt[i], pw, dw);
        exp_err = m_err;
        if (total > MAXBAL) begin
            total   = MAXBAL;
            exp_err = 1'b1;
        end
        bus.round_done = 1'b1;
        bus.player_win = pw;
        bus.dealer_win = dw;
        if (collide) begin
            bus.bet_valid  = 1'b1;
            bus.bet_type   = BET_PLAYER;
            bus.bet_amount = BET_W'(1);
        end
        #1;
        n_checks++;
        if (bus.bet_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL round_ready: got %0b expected 0", bus.bet_ready);
        end
        @(posedge clk);
        #1;
        bus.round_done = 1'b0;
        cycles = 1;
        busy   = 0;
        while (!bus.settle_done && cycles <= NBETS + 4) begin
            if (bus.settle_busy) busy++;
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.bet_valid = 1'b0;
        $display("round pw=%0b dw=%0b bets=%0d latency=%0d balance=%0d err=%0b",
                 pw, dw, n, cycles, bus.balance, bus.money_err);
        n_checks++;
        if (bus.settle_done !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_timeout: got %0b expected 1", bus.settle_done);
        end
        n_checks++;
        if (cycles != n + 1) begin
            n_fail++;
            $display("FAIL settle_latency: got %0d expected %0d", cycles, n + 1);
        end
        n_checks++;
        if (busy != n) begin
            n_fail++;
            $display("FAIL settle_busy_cycles: got %0d expected %0d", busy, n);
        end
        n_checks++;
        if (bus.balance !== BAL_W'(total)) begin
            n_fail++;
            $display("FAIL settle_balance: got %0d expected %0d", bus.balance, total);
        end
        n_checks++;
        if (bus.money_err !== exp_err) begin
            n_fail++;
            $display("FAIL settle_money_err: got %0b expected %0b", bus.money_err, exp_err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.bet_count !== '0 || bus.settle_done !== 1'b0 || bus.settle_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_round: got count=%0d done=%0b busy=%0b expected 0 0 0",
                     bus.bet_count, bus.settle_done, bus.settle_busy);
        end
        n_checks++;
        if (bus.balance !== BAL_W'(total)) begin
            n_fail++;
            $display("FAIL post_round_balance: got %0d expected %0d", bus.balance, total);
        end
        m_bal = total;
        m_err = exp_err;
        q_kind.delete();
        q_amt.delete();
    endtask

    task automatic test_reset();
        do_reset();
        $display("reset balance=%0d ready=%0b count=%0d", bus.balance, bus.bet_ready, bus.bet_count);
        n_checks++;
        if (bus.balance !== BAL_W'(INIT_BAL) || bus.bet_ready !== 1'b1 || bus.bet_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got bal=%0d ready=%0b count=%0d expected %0d 1 0",
                     bus.balance, bus.bet_ready, bus.bet_count, INIT_BAL);
        end
        n_checks++;
        if ({bus.bet_reject, bus.money_err, bus.settle_busy, bus.settle_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.bet_reject, bus.money_err, bus.settle_busy, bus.settle_done});
        end
    endtask

    task automatic test_player_win();
        do_reset();
        place_bet(BET_PLAYER, 20);
        run_round(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_tie();
        do_reset();
        place_bet(BET_TIE, 10);
        place_bet(BET_BANKER, 5);
        run_round(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reject();
        do_reset();
        place_bet(BET_PLAYER, 101);
        place_bet(BET_NONE, 5);
        place_bet(BET_BANKER, 0);
        place_bet(BET_BANKER, 100);
        run_round(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        do_reset();
        place_bet(BET_PLAYER, 100);
        run_round(1'b1, 1'b0, 1'b0);
        place_bet(BET_TIE, 20);
        run_round(1'b1, 1'b1, 1'b0);
        place_bet(BET_PLAYER, 1);
        run_round(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_full_and_priority();
        do_reset();
        place_bet(BET_PLAYER, 5);
        place_bet(BET_BANKER, 6);
        place_bet(BET_TIE, 7);
        place_bet(BET_PLAYER, 8);
        place_bet(BET_PLAYER, 9);
        run_round(1'b0, 1'b1, 1'b0);
        place_bet(BET_PLAYER, 10);
        run_round(1'b1, 1'b0, 1'b1);
        run_round(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_settle();
        do_reset();
        place_bet(BET_PLAYER, 10);
        place_bet(BET_PLAYER, 10);
        place_bet(BET_BANKER, 10);
        bus.round_done = 1'b1;
        bus.player_win = 1'b1;
        bus.dealer_win = 1'b0;
        @(posedge clk);
        #1;
        bus.round_done = 1'b0;
        n_checks++;
        if (bus.settle_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midsettle_busy: got %0b expected 1", bus.settle_busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        $display("reset during settle balance=%0d count=%0d busy=%0b", bus.balance, bus.bet_count, bus.settle_busy);
        n_checks++;
        if (bus.balance !== BAL_W'(INIT_BAL) || bus.bet_count !== '0 || bus.settle_busy !== 1'b0 ||
            bus.settle_done !== 1'b0 || bus.bet_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midsettle_reset: got bal=%0d count=%0d busy=%0b done=%0b ready=%0b",
                     bus.balance, bus.bet_count, bus.settle_busy, bus.settle_done, bus.bet_ready);
        end
        place_bet(BET_BANKER, 30);
        run_round(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int offers;
        for (int r = 0; r < 40; r++) begin
            if (m_bal < 10) do_reset();
            offers = $urandom_range(0, 5);
            for (int k = 0; k < offers; k++)
                place_bet(2'($urandom_range(0, 3)), $urandom_range(0, 60));
            run_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_player_win();
        test_tie();
        test_reject();
        test_saturate();
        test_full_and_priority();
        test_reset_mid_settle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
